// File: rtl/pipe_latch_elastic_if.sv
// Handshake and status bundle for pipe_latch_elastic.
// master drives the stage controls and payload; slave is the buffer itself.
interface pipe_latch_elastic_if #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
);
    localparam int AW = $clog2(DEPTH);

    logic [1:0]       ctr;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic [AW:0]      occupancy;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             illegal_ctr;

    modport master (
        output ctr, in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out, occupancy, stall_cnt, flush_cnt, illegal_ctr
    );

    modport slave (
        input  ctr, in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out, occupancy, stall_cnt, flush_cnt, illegal_ctr
    );
endinterface

// File: rtl/pipe_latch_elastic.sv
// Elastic pipeline stage latch: DEPTH-entry circular buffer with stall/flush
// control, sticky reserved-code flag and saturating stall/flush counters.
module pipe_latch_elastic #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input logic                clk,
    input logic                rst,
    pipe_latch_elastic_if.slave bus
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             illegal_ctr;

    logic             flush, stall, push, pop, out_valid;
    logic [CNT_W:0]   flush_sum;

    // Reserved code 11 shares the flush path; only ctr[1] matters here.
    assign flush     = bus.ctr[1];
    assign stall     = (bus.ctr == 2'b01);
    assign out_valid = (count != '0);

    // in_ready ignores out_ready so no comb path runs downstream->upstream.
    assign bus.in_ready = (count != FULL) && !flush;
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = out_valid && bus.out_ready && (bus.ctr == 2'b00);

    assign flush_sum = {1'b0, flush_cnt} + (CNT_W+1)'(count);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            illegal_ctr <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;

            if (flush) begin
                // push is blocked while flushing, so wr_ptr is stable this edge
                rd_ptr    <= wr_ptr;
                count     <= '0;
                flush_cnt <= flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
            end else begin
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end

            if (stall && out_valid && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (bus.ctr == 2'b11) illegal_ctr <= 1'b1;
        end
    end

    assign bus.out_valid   = out_valid;
    assign bus.data_out    = out_valid ? mem[rd_ptr] : '0;
    assign bus.occupancy   = count;
    assign bus.stall_cnt   = stall_cnt;
    assign bus.flush_cnt   = flush_cnt;
    assign bus.illegal_ctr = illegal_ctr;
endmodule

// File: tb/tb_pipe_latch_elastic.sv
// Drives two buffers (DEPTH=2/CNT_W=16 and DEPTH=4/CNT_W=4) from one stimulus
// stream and checks both against a queue-based model every cycle.
module tb_pipe_latch_elastic;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ctr;
    logic        in_valid;
    logic [63:0] data_in;
    logic        out_ready;

    logic [1:0]  o_valid, o_ready, o_ill;
    logic [63:0] o_data [2];
    logic [7:0]  o_occ  [2];
    logic [15:0] o_sc   [2];
    logic [15:0] o_fc   [2];

    int pass_cnt = 0;
    int total    = 0;
    bit chk_en   = 1'b0;

    // Model: a plain FIFO of payloads plus integer counters per instance.
    logic [63:0] mq [2][$];
    int          m_sc  [2];
    int          m_fc  [2];
    bit          m_ill [2];
    int          m_dep [2] = '{2, 4};
    int          m_max [2] = '{65535, 15};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int D = (g == 0) ? 2 : 4;
        localparam int C = (g == 0) ? 16 : 4;
        pipe_latch_elastic_if #(.WIDTH(64), .DEPTH(D), .CNT_W(C)) bus ();
        assign bus.ctr       = ctr;
        assign bus.in_valid  = in_valid;
        assign bus.data_in   = data_in;
        assign bus.out_ready = out_ready;
        assign o_valid[g]    = bus.out_valid;
        assign o_ready[g]    = bus.in_ready;
        assign o_ill[g]      = bus.illegal_ctr;
        assign o_data[g]     = bus.data_out;
        assign o_occ[g]      = 8'(bus.occupancy);
        assign o_sc[g]       = 16'(bus.stall_cnt);
        assign o_fc[g]       = 16'(bus.flush_cnt);
        pipe_latch_elastic #(.WIDTH(64), .DEPTH(D), .CNT_W(C)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int sz;
            bit ir;
            sz = mq[i].size();
            ir = (sz < m_dep[i]) && !ctr[1];
            if (rst) begin
                mq[i].delete();
                m_sc[i] = 0; m_fc[i] = 0; m_ill[i] = 0;
            end else if (ctr[1]) begin
                m_fc[i] = (m_fc[i] + sz > m_max[i]) ? m_max[i] : m_fc[i] + sz;
                mq[i].delete();
                if (ctr == 2'b11) m_ill[i] = 1;
            end else begin
                if (ctr == 2'b01 && sz > 0 && m_sc[i] < m_max[i]) m_sc[i]++;
                if (ctr == 2'b00 && sz > 0 && out_ready) void'(mq[i].pop_front());
                if (in_valid && ir) mq[i].push_back(data_in);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                int sz;
                sz = mq[i].size();
                check($sformatf("u%0d.out_valid", i), 64'(o_valid[i]), 64'(sz != 0));
                check($sformatf("u%0d.data_out", i), o_data[i], (sz != 0) ? mq[i][0] : 64'h0);
                check($sformatf("u%0d.occupancy", i), 64'(o_occ[i]), 64'(sz));
                check($sformatf("u%0d.in_ready", i), 64'(o_ready[i]), 64'((sz < m_dep[i]) && !ctr[1]));
                check($sformatf("u%0d.stall_cnt", i), 64'(o_sc[i]), 64'(m_sc[i]));
                check($sformatf("u%0d.flush_cnt", i), 64'(o_fc[i]), 64'(m_fc[i]));
                check($sformatf("u%0d.illegal_ctr", i), 64'(o_ill[i]), 64'(m_ill[i]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [1:0] c, input logic iv,
                         input logic [63:0] d, input logic ordy);
        rst = r; ctr = c; in_valid = iv; data_in = d; out_ready = ordy;
    endtask

    initial begin
        logic [63:0] got [$];
        int acc;
        drive(1, 2'b00, 0, 64'h0, 0);
        tick(); tick();
        drive(0, 2'b00, 0, 64'h0, 1);
        chk_en = 1'b1;
        check("reset.out_valid", 64'(o_valid[0]), 64'h0);
        check("reset.data_out", o_data[0], 64'h0);
        check("reset.occupancy", 64'(o_occ[0]), 64'h0);
        check("reset.in_ready", 64'(o_ready[0]), 64'h1);

        // single push, 1-cycle latency then bubble
        drive(0, 2'b00, 1, 64'hA5, 1);
        tick();
        in_valid = 0;
        check("lat.out_valid", 64'(o_valid[0]), 64'h1);
        check("lat.data_out", o_data[0], 64'hA5);
        check("lat.occupancy", 64'(o_occ[0]), 64'h1);
        tick();
        check("lat.drain_occ", 64'(o_occ[0]), 64'h0);
        check("lat.drain_data", o_data[0], 64'h0);

        // fill DEPTH=2 with backpressure; third item refused
        drive(0, 2'b00, 1, 64'h1, 0);
        tick();
        data_in = 64'h2;
        tick();
        check("full.occupancy", 64'(o_occ[0]), 64'h2);
        check("full.in_ready", 64'(o_ready[0]), 64'h0);
        data_in = 64'h3;
        tick();
        check("full.no_accept", 64'(o_occ[0]), 64'h2);
        check("full.d4_accept", 64'(o_occ[1]), 64'h3);
        drive(0, 2'b00, 0, 64'h0, 1);
        check("order.first", o_data[0], 64'h1);
        tick();
        check("order.second", o_data[0], 64'h2);
        tick(); tick();
        check("order.empty", 64'(o_occ[0]), 64'h0);

        // stall five cycles with head 7, push 8 during the stall
        drive(0, 2'b00, 1, 64'h7, 1);
        tick();
        drive(0, 2'b01, 1, 64'h8, 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            in_valid = 0;
            check("stall.hold", o_data[0], 64'h7);
        end
        check("stall.cnt5", 64'(o_sc[0]), 64'd5);
        check("stall.occ2", 64'(o_occ[0]), 64'h2);

        // flush with two entries held
        drive(0, 2'b10, 1, 64'hEE, 1);
        #1;
        check("flush.in_ready", 64'(o_ready[0]), 64'h0);
        tick();
        drive(0, 2'b00, 0, 64'h0, 1);
        check("flush.out_valid", 64'(o_valid[0]), 64'h0);
        check("flush.data_out", o_data[0], 64'h0);
        check("flush.occupancy", 64'(o_occ[0]), 64'h0);
        check("flush.cnt2", 64'(o_fc[0]), 64'h2);

        // reserved code: flush plus sticky flag
        drive(0, 2'b00, 1, 64'h9, 0);
        tick();
        drive(0, 2'b11, 0, 64'h0, 0);
        tick();
        ctr = 2'b00;
        check("ill.flag", 64'(o_ill[0]), 64'h1);
        check("ill.flush_cnt", 64'(o_fc[0]), 64'h3);
        tick(); tick();
        check("ill.sticky", 64'(o_ill[0]), 64'h1);

        // long stall: CNT_W=4 instance saturates at 15
        drive(0, 2'b00, 1, 64'hB, 0);
        tick();
        drive(0, 2'b01, 0, 64'h0, 1);
        for (int k = 0; k < 20; k++) tick();
        check("sat.cnt4", 64'(o_sc[1]), 64'd15);
        check("sat.cnt16", 64'(o_sc[0]), 64'd25);
        ctr = 2'b00;
        tick();

        drive(1, 2'b00, 0, 64'h0, 1);
        tick();
        rst = 0;
        check("rst.ill", 64'(o_ill[0]), 64'h0);
        check("rst.stall", 64'(o_sc[0]), 64'h0);
        check("rst.flush", 64'(o_fc[0]), 64'h0);

        // stream 10 items through DEPTH=4 with intermittent backpressure
        acc = 0;
        for (int k = 0; k < 60 && (acc < 10 || o_valid[1]); k++) begin
            in_valid  = (acc < 10);
            data_in   = 64'h10 + 64'(acc);
            out_ready = (k % 3) != 0;
            #1;
            if (o_valid[1] && out_ready) got.push_back(o_data[1]);
            if (in_valid && o_ready[1]) acc++;
            tick();
        end
        in_valid = 0;
        check("wrap.count", 64'(got.size()), 64'd10);
        for (int k = 0; k < 10 && k < got.size(); k++)
            check($sformatf("wrap.item%0d", k), got[k], 64'h10 + 64'(k));

        tick();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
